// File: rtl/srgl_pkg.sv
// srgl_pkg -- shared types and constants for the gesture-matching sequencer.
//   srgl_state_e : sequencer states
//   TPL_LETTER   : ASCII letter assigned to each stored movement template
//   ASCII_*      : letter codes shared with the LDR decoder
//   *_DEF        : default template count, samples per template, sample width
package srgl_pkg;

  localparam int N_TPL_DEF  = 10;
  localparam int N_SAMP_DEF = 30;
  localparam int DW_DEF     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_CMP,
    ST_DECIDE,
    ST_OUT
  } srgl_state_e;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_H = 8'h48;
  localparam logic [7:0] ASCII_J = 8'h4A;
  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_P = 8'h50;
  localparam logic [7:0] ASCII_Q = 8'h51;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_W = 8'h57;
  localparam logic [7:0] ASCII_X = 8'h58;
  localparam logic [7:0] ASCII_Y = 8'h59;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  // Letters that need a movement to be signed; index = template number.
  localparam logic [7:0] TPL_LETTER [N_TPL_DEF] = '{
    ASCII_J, ASCII_Z, ASCII_H, ASCII_K, ASCII_X,
    ASCII_Y, ASCII_Q, ASCII_P, ASCII_G, ASCII_W
  };

endpackage

// File: rtl/srgl_match_ctrl_sad_acc.sv
// srgl_sad_acc -- signed abs-difference, saturating accumulator.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears the sum)
//   clr_i        : synchronous clear, wins over en_i
//   en_i         : add |a_i - b_i| to the running sum
//   a_i, b_i     : signed samples, DW bits
//   sad_o        : running sum, ACC_W bits, saturates at all-ones
module srgl_sad_acc
  import srgl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic [ACC_W-1:0]     sad_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DW:0]      diff;
  logic [DW:0]      mag;
  logic [ACC_W:0]   sum;

  // Sign-extend by one bit so the difference of any two samples cannot wrap.
  always_comb begin
    diff = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};
    mag  = diff[DW] ? (~diff + 1'b1) : diff;
    sum  = {1'b0, acc_q} + (ACC_W+1)'(mag);
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign sad_o = acc_q;

endmodule

// File: rtl/srgl_match_ctrl.sv
// srgl_match_ctrl -- gesture template matching sequencer.
// Walks every template, streams the capture buffer and template ROM through
// one abs-difference accumulator, keeps the closest template, then presents
// either the matched dynamic letter or the static LDR letter on out_*.
// Build option: SRGL_EARLY_ABORT_EN stops reading a template as soon as its
// partial sum can no longer beat the best one found so far.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   start_i, mov_i, letter_base_i : request, movement flag, LDR letter
//   busy_o                      : high outside IDLE
//   samp_rd_en_o/addr_o/data_i  : capture buffer read port (1-cycle latency)
//   tpl_rd_en_o/addr_o/data_i   : template ROM read port (1-cycle latency)
//   out_valid_o/ready_i         : result handshake
//   out_letter_o/matched_o/idx_o: result
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_ACC    | reading one template and accumulating its SAD
// ST_CMP    | compare template SAD with best, advance template
// ST_DECIDE | apply threshold, register the result
// ST_OUT    | result valid, waiting for out_ready
module srgl_match_ctrl
  import srgl_pkg::*;
#(
  parameter int          N_TPL   = N_TPL_DEF,
  parameter int          N_SAMP  = N_SAMP_DEF,
  parameter int          DW      = DW_DEF,
  parameter int          ACC_W   = 40,
  parameter logic [31:0] TOL_SUM = 32'd3000,
  localparam int SAW = $clog2(N_SAMP),
  localparam int TAW = $clog2(N_TPL*N_SAMP),
  localparam int IW  = $clog2(N_TPL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 mov_i,
  input  logic [7:0]           letter_base_i,
  output logic                 busy_o,
  output logic                 samp_rd_en_o,
  output logic [SAW-1:0]       samp_addr_o,
  input  logic signed [DW-1:0] samp_data_i,
  output logic                 tpl_rd_en_o,
  output logic [TAW-1:0]       tpl_addr_o,
  input  logic signed [DW-1:0] tpl_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [7:0]           out_letter_o,
  output logic                 out_matched_o,
  output logic [IW-1:0]        out_idx_o
);

  localparam int KW = $clog2(N_SAMP+1);

  srgl_state_e      state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    t_q, t_d;
  logic [TAW-1:0]   base_q, base_d;
  logic             pend_q, pend_d;
  logic             pend_last_q, pend_last_d;
  logic [ACC_W-1:0] best_sad_q, best_sad_d;
  logic [IW-1:0]    best_idx_q, best_idx_d;
  logic             best_vld_q, best_vld_d;
  logic [7:0]       letter_q, letter_d;
  logic [7:0]       out_letter_q, out_letter_d;
  logic             out_matched_q, out_matched_d;
  logic [IW-1:0]    out_idx_q, out_idx_d;

  logic             rd_en;
  logic             acc_clr;
  logic             acc_en;
  logic             abort_c;
  logic [ACC_W-1:0] sad;

  srgl_sad_acc #(.DW(DW), .ACC_W(ACC_W)) u_sad_acc (
    .clk   (clk),
    .reset (reset),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .a_i   (samp_data_i),
    .b_i   (tpl_data_i),
    .sad_o (sad)
  );

`ifdef SRGL_EARLY_ABORT_EN
  // Once the partial sum reaches the best full sum this template cannot win
  // (ties keep the lower index), so the rest of its reads are wasted.
  assign abort_c = (state_q == ST_ACC) && best_vld_q && (sad >= best_sad_q);
`else
  assign abort_c = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    t_d           = t_q;
    base_d        = base_q;
    best_sad_d    = best_sad_q;
    best_idx_d    = best_idx_q;
    best_vld_d    = best_vld_q;
    letter_d      = letter_q;
    out_letter_d  = out_letter_q;
    out_matched_d = out_matched_q;
    out_idx_d     = out_idx_q;
    rd_en         = 1'b0;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          letter_d   = letter_base_i;
          t_d        = '0;
          k_d        = '0;
          base_d     = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          best_vld_d = 1'b0;
          // The static path goes through DECIDE: best_sad is all-ones there,
          // so the threshold test falls back to the latched letter.
          state_d    = mov_i ? ST_ACC : ST_DECIDE;
        end
      end

      ST_ACC: begin
        rd_en  = (k_q != KW'(N_SAMP)) && !abort_c;
        acc_en = pend_q && !abort_c;
        if (rd_en) k_d = k_q + 1'b1;
        // On abort, wait out the single word still in flight, then compare.
        if ((abort_c && !pend_q) || (!abort_c && pend_last_q))
          state_d = ST_CMP;
      end

      ST_CMP: begin
        acc_clr    = 1'b1;
        best_vld_d = 1'b1;
        if (sad < best_sad_q) begin
          best_sad_d = sad;
          best_idx_d = t_q;
        end
        if (t_q == IW'(N_TPL-1)) begin
          state_d = ST_DECIDE;
        end else begin
          t_d     = t_q + 1'b1;
          k_d     = '0;
          base_d  = base_q + TAW'(N_SAMP);
          state_d = ST_ACC;
        end
      end

      ST_DECIDE: begin
        if (best_sad_q < ACC_W'(TOL_SUM)) begin
          out_letter_d  = TPL_LETTER[best_idx_q];
          out_matched_d = 1'b1;
          out_idx_d     = best_idx_q;
        end else begin
          out_letter_d  = letter_q;
          out_matched_d = 1'b0;
          out_idx_d     = '0;
        end
        state_d = ST_OUT;
      end

      ST_OUT: begin
        if (out_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    pend_d      = rd_en;
    pend_last_d = rd_en && (k_q == KW'(N_SAMP-1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      t_q           <= '0;
      base_q        <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      best_sad_q    <= '1;
      best_idx_q    <= '0;
      best_vld_q    <= 1'b0;
      letter_q      <= '0;
      out_letter_q  <= '0;
      out_matched_q <= 1'b0;
      out_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      t_q           <= t_d;
      base_q        <= base_d;
      pend_q        <= pend_d;
      pend_last_q   <= pend_last_d;
      best_sad_q    <= best_sad_d;
      best_idx_q    <= best_idx_d;
      best_vld_q    <= best_vld_d;
      letter_q      <= letter_d;
      out_letter_q  <= out_letter_d;
      out_matched_q <= out_matched_d;
      out_idx_q     <= out_idx_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign samp_rd_en_o  = rd_en;
  assign tpl_rd_en_o   = rd_en;
  assign samp_addr_o   = rd_en ? SAW'(k_q) : '0;
  assign tpl_addr_o    = rd_en ? (base_q + TAW'(k_q)) : '0;
  assign out_valid_o   = (state_q == ST_OUT);
  assign out_letter_o  = out_letter_q;
  assign out_matched_o = out_matched_q;
  assign out_idx_o     = out_idx_q;

endmodule

// File: tb/tb_srgl_match_ctrl.sv
module tb_srgl_match_ctrl;

  localparam int NT = 10;
  localparam int NS = 30;
  localparam int FULL_LAT = NT*(NS+2)+1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               mov = 1'b0;
  logic [7:0]         letter_base = 8'h00;
  logic               busy;
  logic               samp_rd_en;
  logic [4:0]         samp_addr;
  logic signed [31:0] samp_data = '0;
  logic               tpl_rd_en;
  logic [8:0]         tpl_addr;
  logic signed [31:0] tpl_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_letter;
  logic               out_matched;
  logic [3:0]         out_idx;

  logic signed [31:0] samp_mem [NS];
  logic signed [31:0] tpl_mem  [NT*NS];
  int                 rd_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srgl_match_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start),
    .mov_i         (mov),
    .letter_base_i (letter_base),
    .busy_o        (busy),
    .samp_rd_en_o  (samp_rd_en),
    .samp_addr_o   (samp_addr),
    .samp_data_i   (samp_data),
    .tpl_rd_en_o   (tpl_rd_en),
    .tpl_addr_o    (tpl_addr),
    .tpl_data_i    (tpl_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_letter_o  (out_letter),
    .out_matched_o (out_matched),
    .out_idx_o     (out_idx)
  );

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    if (samp_rd_en) begin
      samp_data <= samp_mem[samp_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (tpl_rd_en) tpl_data <= tpl_mem[tpl_addr];
  end

  typedef struct {
    string       name;
    logic        mov;
    logic [7:0]  base;
    int          tgt;
    int          off_tgt;
    int          tgt2;
    int          off_tgt2;
    int          off_other;
    logic [7:0]  e_letter;
    logic        e_match;
    logic [3:0]  e_idx;
    int          e_lat;
    int          e_reads;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int k = 0; k < NS; k++) samp_mem[k] = k*1234 - 17000;
    for (int t = 0; t < NT; t++) begin
      int off;
      off = (t == v.tgt) ? v.off_tgt : ((t == v.tgt2) ? v.off_tgt2 : v.off_other);
      for (int k = 0; k < NS; k++) tpl_mem[t*NS+k] = samp_mem[k] + off;
    end
  endtask

  // Issues a start, returns the cycle count until out_valid and reads issued.
  task automatic issue(input logic m, input logic [7:0] b, output int lat, output int reads);
    int rd0;
    @(negedge clk);
    start = 1'b1; mov = m; letter_base = b;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    reads = rd_cnt - rd0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " valid drop"}, {63'd0, out_valid}, 64'd0);
    chk({name, " idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat, reads;
    load_mem(v);
    issue(v.mov, v.base, lat, reads);
    chk({v.name, " valid"}, {63'd0, out_valid}, 64'd1);
`ifdef SRGL_EARLY_ABORT_EN
    chk({v.name, " lat bound"}, {63'd0, (lat <= v.e_lat) && (lat >= 1)}, 64'd1);
    chk({v.name, " reads bound"}, {63'd0, reads <= v.e_reads}, 64'd1);
`else
    chk({v.name, " latency"}, 64'(lat), 64'(v.e_lat));
    chk({v.name, " reads"}, 64'(reads), 64'(v.e_reads));
`endif
    chk({v.name, " letter"}, 64'(out_letter), 64'(v.e_letter));
    chk({v.name, " matched"}, {63'd0, out_matched}, {63'd0, v.e_match});
    chk({v.name, " idx"}, 64'(out_idx), 64'(v.e_idx));
    handshake(v.name);
  endtask

  initial begin
    int lat, reads;
    logic [7:0] held;

    //            name       mov base   tgt off  tgt2 off2 other letter  m idx lat       reads
    vecs[0] = '{"static",   1'b0, 8'h41, -1, 0,   -1, 0,    0,    8'h41, 1'b0, 4'd0, 1,        0};
    vecs[1] = '{"exact3",   1'b1, 8'h41,  3, 0,   -1, 0,    1000, 8'h4B, 1'b1, 4'd3, FULL_LAT, NT*NS};
    vecs[2] = '{"tol_eq",   1'b1, 8'h53,  0, 100, -1, 0,    100,  8'h53, 1'b0, 4'd0, FULL_LAT, NT*NS};
    vecs[3] = '{"tol_lt",   1'b1, 8'h53,  0, 99,  -1, 0,    99,   8'h4A, 1'b1, 4'd0, FULL_LAT, NT*NS};
    vecs[4] = '{"tie25",    1'b1, 8'h41,  2, 1,    5, -1,   500,  8'h48, 1'b1, 4'd2, FULL_LAT, NT*NS};
    vecs[5] = '{"neg7",     1'b1, 8'h42,  7, -50, -1, 0,    -2000,8'h50, 1'b1, 4'd7, FULL_LAT, NT*NS};

    #1;
    chk("rst busy",    {63'd0, busy}, 64'd0);
    chk("rst valid",   {63'd0, out_valid}, 64'd0);
    chk("rst rd_en",   {62'd0, samp_rd_en, tpl_rd_en}, 64'd0);
    chk("rst outputs", {out_letter, out_matched, out_idx}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure, plus a start pulse while busy that must be ignored.
    load_mem(vecs[0]);
    issue(1'b0, 8'h44, lat, reads);
    chk("bp valid", {63'd0, out_valid}, 64'd1);
    held = out_letter;
    chk("bp letter", 64'(held), 64'h44);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin start = 1'b1; mov = 1'b0; letter_base = 8'h45; end
      if (c == 4) start = 1'b0;
      @(posedge clk); #1;
      chk("bp hold valid", {63'd0, out_valid}, 64'd1);
      chk("bp hold letter", 64'(out_letter), 64'h44);
    end
    start = 1'b0;
    handshake("bp");
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp no second", {62'd0, out_valid, busy}, 64'd0);
    end

    // Reset while accumulating template 4.
    load_mem(vecs[1]);
    @(negedge clk);
    start = 1'b1; mov = 1'b1; letter_base = 8'h41;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4*(NS+2) + 10) @(posedge clk);
    #2;
    chk("pre-rst rd_en", {63'd0, samp_rd_en}, 64'd1);
    reset = 1'b1;
    #1;
    chk("arst busy",  {63'd0, busy}, 64'd0);
    chk("arst rd_en", {62'd0, samp_rd_en, tpl_rd_en}, 64'd0);
    chk("arst addr",  {50'd0, samp_addr, tpl_addr}, 64'd0);
    chk("arst out",   {out_valid, out_letter, out_matched, out_idx}, 64'd0);
    @(negedge clk); reset = 1'b0;
    run_vec(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
